// File: rtl/blck_serializer.sv
// blck_serializer
//   Accepts one wide data block (BLCK_SIZE bits plus per-byte validity) and
//   emits it as a stream of BUS_SIZE-bit words, word 0 first, with
//   valid/ready handshaking on both sides. Only one block is held at a time:
//   the input is not ready while a block is being sent. A block whose first
//   byte is invalid is accepted and silently dropped.
//
// Parameters
//   BUS_SIZE          output word width in bits (8, 16 or 32)
//   BLCK_SIZE         input block width in bits (multiple of BUS_SIZE)
//
// Ports
//   clk               clock, rising edge
//   rst               synchronous active-high reset
//   blck_in           input block, word k = bits [(k+1)*BUS_SIZE-1 : k*BUS_SIZE]
//   blck_in_validity  per-byte validity of blck_in, contiguous from bit 0
//   blck_in_last      block is the final block of its stream
//   blck_in_valid     block offered
//   blck_in_ready     block accepted when high together with blck_in_valid
//   data_out          serialized word, invalid bytes forced to zero
//   data_out_validity per-byte validity of data_out
//   data_out_last     final word of a last block
//   data_out_valid    word offered
//   data_out_ready    word consumed when high together with data_out_valid
module blck_serializer #(
    parameter int BUS_SIZE  = 32,
    parameter int BLCK_SIZE = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [BLCK_SIZE-1:0]   blck_in,
    input  logic [BLCK_SIZE/8-1:0] blck_in_validity,
    input  logic                   blck_in_last,
    input  logic                   blck_in_valid,
    output logic                   blck_in_ready,
    output logic [BUS_SIZE-1:0]    data_out,
    output logic [BUS_SIZE/8-1:0]  data_out_validity,
    output logic                   data_out_last,
    output logic                   data_out_valid,
    input  logic                   data_out_ready
);

    localparam int BUSdiv8  = BUS_SIZE / 8;
    localparam int BLCKdiv8 = BLCK_SIZE / 8;
    localparam int NWORDS   = BLCK_SIZE / BUS_SIZE;
    localparam int CNT_W    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NWORDS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                state;
    state_t                state_next;

    logic [BLCK_SIZE-1:0]  buffer;
    logic [BLCKdiv8-1:0]   vbuf;
    logic                  last_r;
    logic [CNT_W-1:0]      cnt;

    logic                  capture;
    logic                  advance;
    logic                  final_word;

    // One spare zero bit above vbuf so the "next word empty" probe stays in
    // range even when the block is a single word.
    logic [BLCKdiv8:0]     vbuf_ext;

    // Zero every byte whose validity bit is clear.
    function automatic logic [BUS_SIZE-1:0] mask_bytes(
        input logic [BUS_SIZE-1:0] d,
        input logic [BUSdiv8-1:0]  v
    );
        logic [BUS_SIZE-1:0] m;
        m = '0;
        for (int i = 0; i < BUSdiv8; i++) begin
            m[i*8 +: 8] = v[i] ? d[i*8 +: 8] : 8'h00;
        end
        return m;
    endfunction

    assign vbuf_ext   = {1'b0, vbuf};
    // Current word is the last one when the block is exhausted or the
    // following word carries no valid byte (validity is contiguous).
    assign final_word = (cnt == LAST_CNT) || !vbuf_ext[BUSdiv8];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Outputs depend only on registered state/datapath; data_out_ready only
    // steers next-state and the advance strobe.
    always_comb begin
        state_next        = state;
        blck_in_ready     = 1'b0;
        data_out_valid    = 1'b0;
        data_out          = '0;
        data_out_validity = '0;
        data_out_last     = 1'b0;
        capture           = 1'b0;
        advance           = 1'b0;
        case (state)
            IDLE: begin
                blck_in_ready = 1'b1;
                if (blck_in_valid) begin
                    capture = 1'b1;
                    if (blck_in_validity[0]) begin
                        state_next = SEND;
                    end
                end
            end
            SEND: begin
                data_out_valid    = 1'b1;
                data_out          = mask_bytes(buffer[BUS_SIZE-1:0], vbuf[BUSdiv8-1:0]);
                data_out_validity = vbuf[BUSdiv8-1:0];
                data_out_last     = final_word && last_r;
                if (data_out_ready) begin
                    advance = 1'b1;
                    if (final_word) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buffer <= '0;
            vbuf   <= '0;
            last_r <= 1'b0;
            cnt    <= '0;
        end else if (capture) begin
            buffer <= blck_in;
            vbuf   <= blck_in_validity;
            last_r <= blck_in_last;
            cnt    <= '0;
        end else if (advance) begin
            buffer <= buffer >> BUS_SIZE;
            vbuf   <= vbuf >> BUSdiv8;
            // Holding on the final word keeps the counter from wrapping.
            if (!final_word) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_blck_serializer.sv
module tb_blck_serializer;

    localparam int BUS_SIZE  = 32;
    localparam int BLCK_SIZE = 256;
    localparam int NW        = BLCK_SIZE / BUS_SIZE;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [BLCK_SIZE-1:0]   blck_in;
    logic [BLCK_SIZE/8-1:0] blck_in_validity;
    logic                   blck_in_last;
    logic                   blck_in_valid;
    logic                   blck_in_ready;
    logic [BUS_SIZE-1:0]    data_out;
    logic [BUS_SIZE/8-1:0]  data_out_validity;
    logic                   data_out_last;
    logic                   data_out_valid;
    logic                   data_out_ready;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  v;
        logic        l;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    blck_serializer #(.BUS_SIZE(BUS_SIZE), .BLCK_SIZE(BLCK_SIZE)) dut (
        .clk               (clk),
        .rst               (rst),
        .blck_in           (blck_in),
        .blck_in_validity  (blck_in_validity),
        .blck_in_last      (blck_in_last),
        .blck_in_valid     (blck_in_valid),
        .blck_in_ready     (blck_in_ready),
        .data_out          (data_out),
        .data_out_validity (data_out_validity),
        .data_out_last     (data_out_last),
        .data_out_valid    (data_out_valid),
        .data_out_ready    (data_out_ready)
    );

    always #5 clk = ~clk;

    // Scoreboard: every accepted output word is compared with the oldest
    // expected word.
    always @(negedge clk) begin
        if (!rst && data_out_valid && data_out_ready) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word: got data=%h validity=%h last=%b, required no word",
                         data_out, data_out_validity, data_out_last);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (data_out !== e.d || data_out_validity !== e.v || data_out_last !== e.l) begin
                    errors++;
                    $display("FAIL word: got data=%h validity=%h last=%b, required data=%h validity=%h last=%b",
                             data_out, data_out_validity, data_out_last, e.d, e.v, e.l);
                end
            end
        end
    end

    function automatic void push_exp(input logic [31:0] d, input logic [3:0] v, input logic l);
        exp_t e;
        e.d = d;
        e.v = v;
        e.l = l;
        q.push_back(e);
    endfunction

    // Offer one block; returns just after the capturing rising edge.
    task automatic send_block(input logic [BLCK_SIZE-1:0] b,
                              input logic [BLCK_SIZE/8-1:0] v,
                              input logic last);
        int n;
        n = 0;
        @(negedge clk);
        while (!blck_in_ready && n < 64) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (!blck_in_ready) begin
            errors++;
            $display("FAIL ready_timeout: got blck_in_ready=%b, required 1", blck_in_ready);
        end
        blck_in          = b;
        blck_in_validity = v;
        blck_in_last     = last;
        blck_in_valid    = 1'b1;
        @(posedge clk);
        #1;
        blck_in_valid    = 1'b0;
    endtask

    // Count consecutive valid cycles starting at the cycle after capture.
    task automatic count_words(output int n);
        n = 0;
        forever begin
            @(negedge clk);
            if (!data_out_valid || n >= 64) break;
            n++;
        end
    endtask

    task automatic check_empty_queue(input string name);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s_pending: got %0d words still expected, required 0", name, q.size());
            q.delete();
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (data_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got %h, required 00000000", data_out);
        end
        checks++;
        if (data_out_validity !== 4'h0) begin
            errors++;
            $display("FAIL reset_validity: got %h, required 0", data_out_validity);
        end
        checks++;
        if (data_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b, required 0", data_out_valid);
        end
        checks++;
        if (data_out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_last: got %b, required 0", data_out_last);
        end
        checks++;
        if (blck_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b, required 1", blck_in_ready);
        end
    endtask

    task automatic test_full_block;
        logic [BLCK_SIZE-1:0] b;
        int n;
        for (int k = 0; k < NW; k++) begin
            b[k*32 +: 32] = 32'(k + 1);
            push_exp(32'(k + 1), 4'hF, k == NW - 1);
        end
        data_out_ready = 1'b1;
        send_block(b, 32'hFFFF_FFFF, 1'b1);
        count_words(n);
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL full_word_count: got %0d consecutive words, required 8", n);
        end
        checks++;
        if (blck_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_ready_after: got %b, required 1", blck_in_ready);
        end
        check_empty_queue("full");
    endtask

    task automatic test_partial_block;
        logic [BLCK_SIZE-1:0] b;
        int n;
        b = '0;
        b[31:0]  = 32'hAABB_CCDD;
        b[63:32] = 32'h1122_3344;
        b[95:64] = 32'h5566_7788;
        push_exp(32'hAABB_CCDD, 4'hF, 1'b0);
        push_exp(32'h0000_3344, 4'h3, 1'b1);
        data_out_ready = 1'b1;
        send_block(b, 32'h0000_003F, 1'b1);
        count_words(n);
        checks++;
        if (n != 2) begin
            errors++;
            $display("FAIL partial_word_count: got %0d, required 2", n);
        end
        check_empty_queue("partial");
    endtask

    task automatic test_backpressure;
        logic [BLCK_SIZE-1:0] b;
        logic [31:0] hd;
        logic [3:0]  hv;
        logic        hl;
        int n;
        for (int k = 0; k < NW; k++) begin
            b[k*32 +: 32] = 32'(k + 1);
            push_exp(32'(k + 1), 4'hF, k == NW - 1);
        end
        data_out_ready = 1'b0;
        send_block(b, 32'hFFFF_FFFF, 1'b1);
        n = 0;
        forever begin
            @(negedge clk);
            if (!data_out_valid || n >= 64) break;
            if (n % 2 == 1) begin
                checks++;
                if (data_out !== hd || data_out_validity !== hv || data_out_last !== hl) begin
                    errors++;
                    $display("FAIL stall_hold: got data=%h validity=%h last=%b, required data=%h validity=%h last=%b",
                             data_out, data_out_validity, data_out_last, hd, hv, hl);
                end
            end else begin
                hd = data_out;
                hv = data_out_validity;
                hl = data_out_last;
            end
            n++;
            @(posedge clk);
            #1;
            data_out_ready = (n % 2 == 1);
        end
        data_out_ready = 1'b1;
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL backpressure_cycles: got %0d, required 16", n);
        end
        check_empty_queue("backpressure");
    endtask

    task automatic test_empty_block;
        logic [BLCK_SIZE-1:0] b;
        b = {8{32'hDEAD_BEEF}};
        data_out_ready = 1'b1;
        send_block(b, 32'h0000_0000, 1'b1);
        @(negedge clk);
        checks++;
        if (blck_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL empty_ready: got %b, required 1", blck_in_ready);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (data_out_valid !== 1'b0 || data_out_last !== 1'b0) begin
                errors++;
                $display("FAIL empty_no_word: got valid=%b last=%b, required 0/0",
                         data_out_valid, data_out_last);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_block;
        logic [BLCK_SIZE-1:0] b;
        int hs;
        for (int k = 0; k < NW; k++) begin
            b[k*32 +: 32] = 32'(k + 1);
        end
        for (int k = 0; k < 3; k++) begin
            push_exp(32'(k + 1), 4'hF, 1'b0);
        end
        data_out_ready = 1'b1;
        send_block(b, 32'hFFFF_FFFF, 1'b1);
        // Three handshakes on the following three rising edges.
        hs = 0;
        repeat (3) begin
            @(negedge clk);
            if (data_out_valid) hs++;
            @(posedge clk);
        end
        #1;
        data_out_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        data_out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (hs != 3) begin
            errors++;
            $display("FAIL rstmid_handshakes: got %0d, required 3", hs);
        end
        checks++;
        if (data_out_valid !== 1'b0 || data_out !== 32'h0 || data_out_validity !== 4'h0 ||
            data_out_last !== 1'b0 || blck_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_outputs: got valid=%b data=%h validity=%h last=%b ready=%b, required 0/0/0/0/1",
                     data_out_valid, data_out, data_out_validity, data_out_last, blck_in_ready);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (data_out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_no_word4: got valid=%b data=%h, required valid 0",
                         data_out_valid, data_out);
            end
        end
        check_empty_queue("rstmid");
    endtask

    task automatic test_non_last_block;
        logic [BLCK_SIZE-1:0] b;
        int n;
        for (int k = 0; k < NW; k++) begin
            b[k*32 +: 32] = 32'hC0DE_0000 + 32'(k);
        end
        for (int k = 0; k < 4; k++) begin
            push_exp(32'hC0DE_0000 + 32'(k), 4'hF, 1'b0);
        end
        data_out_ready = 1'b1;
        send_block(b, 32'h0000_FFFF, 1'b0);
        count_words(n);
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL nonlast_word_count: got %0d, required 4", n);
        end
        check_empty_queue("nonlast");
    endtask

    task automatic test_back_to_back;
        logic [BLCK_SIZE-1:0] b;
        int n;
        b = '0;
        b[31:0]  = 32'h0102_0304;
        b[63:32] = 32'hFFEE_DDCC;
        push_exp(32'h0102_0304, 4'hF, 1'b0);
        push_exp(32'h00EE_DDCC, 4'h7, 1'b0);
        data_out_ready = 1'b1;
        send_block(b, 32'h0000_007F, 1'b0);
        count_words(n);
        b[31:0] = 32'h5A5A_A5A5;
        push_exp(32'h0000_00A5, 4'h1, 1'b1);
        send_block(b, 32'h0000_0001, 1'b1);
        count_words(n);
        checks++;
        if (n != 1) begin
            errors++;
            $display("FAIL b2b_word_count: got %0d, required 1", n);
        end
        check_empty_queue("b2b");
    endtask

    initial begin
        rst              = 1'b1;
        blck_in          = '0;
        blck_in_validity = '0;
        blck_in_last     = 1'b0;
        blck_in_valid    = 1'b0;
        data_out_ready   = 1'b1;
        test_reset();
        test_full_block();
        test_partial_block();
        test_backpressure();
        test_empty_block();
        test_reset_mid_block();
        test_non_last_block();
        test_back_to_back();
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
